// File: rtl/move_collector_pkg.sv
// Shared definitions for the move collector: side/piece codes, move-word field
// positions, direction indices and the per-word keep test.
package move_collector_pkg;

    localparam logic WHITE = 1'b1;
    localparam logic BLACK = 1'b0;

    localparam logic [4:0] PAWN   = 5'b00010;
    localparam logic [4:0] KNIGHT = 5'b00001;
    localparam logic [4:0] BISHOP = 5'b01000;
    localparam logic [4:0] ROOK   = 5'b10000;
    localparam logic [4:0] QUEEN  = 5'b11000;
    localparam logic [4:0] KING   = 5'b00100;

    localparam int CAPT_MSB  = 29;
    localparam int CAPT_LSB  = 24;
    localparam int FINAL_MSB = 21;
    localparam int FINAL_LSB = 16;
    localparam int PIECE_MSB = 13;
    localparam int PIECE_LSB = 8;
    localparam int COLOR_BIT = 13;
    localparam int INIT_MSB  = 5;
    localparam int INIT_LSB  = 0;

    localparam logic [31:0] EMPTY_MOVE = 32'h0;

    localparam int DIR_U   = 0;
    localparam int DIR_D   = 1;
    localparam int DIR_L   = 2;
    localparam int DIR_R   = 3;
    localparam int DIR_UL  = 4;
    localparam int DIR_UR  = 5;
    localparam int DIR_DL  = 6;
    localparam int DIR_DR  = 7;
    localparam int DIR_UUL = 8;
    localparam int DIR_UUR = 9;
    localparam int DIR_LLU = 10;
    localparam int DIR_RRU = 11;
    localparam int DIR_DDL = 12;
    localparam int DIR_DDR = 13;
    localparam int DIR_LLD = 14;
    localparam int DIR_RRD = 15;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    // A move survives only if present and made by the side to move.
    function automatic logic is_kept(input logic [31:0] word, input logic color);
        return (word != EMPTY_MOVE) && (word[COLOR_BIT] == color);
    endfunction

endpackage

// File: rtl/move_fifo.sv
// Synchronous FIFO with a registered head word; a push is accepted when full
// provided a pop happens on the same edge.
module move_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_q;
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_next;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] head_next;
    logic             do_pop;
    logic             do_push;

    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && (!full || do_pop);
    assign rd_next = do_pop ? rd_q + AW'(1) : rd_q;

    always_comb begin
        count_next = count_q;
        case ({do_push, do_pop})
            2'b10:   count_next = count_q + CW'(1);
            2'b01:   count_next = count_q - CW'(1);
            default: count_next = count_q;
        endcase
    end

    // The head register looks one edge ahead so the word is visible the cycle
    // after it is pushed, including when it lands in an empty FIFO.
    always_comb begin
        head_next = mem[rd_next];
        if (count_next == '0) begin
            head_next = '0;
        end else if (do_push && (wr_q == rd_next)) begin
            head_next = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            rd_q    <= rd_next;
            wr_q    <= do_push ? wr_q + AW'(1) : wr_q;
            count_q <= count_next;
            head_q  <= head_next;
        end
    end

    assign head  = head_q;
    assign count = count_q;

endmodule

// File: rtl/move_collector.sv
// Filters a square's move bundle to the side to move and compacts survivors,
// lowest direction index first, into a FIFO drained by a valid/ready stream.
module move_collector
    import move_collector_pkg::*;
#(
    parameter int MOVE_W  = 32,
    parameter int NUM_DIR = 16,
    parameter int DEPTH   = 16,
    localparam int IW = $clog2(NUM_DIR),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      clear_n,
    input  logic                      engineColor,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_DIR*MOVE_W-1:0] move_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MOVE_W-1:0]         move_out,
    output logic [CW-1:0]             fifo_count,
    output logic [15:0]               moves_total,
    output logic                      busy
);

    state_t               state_q;
    state_t               state_d;
    logic [NUM_DIR-1:0]   mask_q;
    logic [NUM_DIR-1:0]   mask_d;
    logic [NUM_DIR-1:0]   keep_mask;
    logic [NUM_DIR-1:0]   mask_rest;
    logic [IW-1:0]        sel_idx;
    logic [MOVE_W-1:0]    bundle_q [NUM_DIR];
    logic [MOVE_W-1:0]    sel_word;
    logic [15:0]          moves_total_q;
    logic                 accept;
    logic                 push;
    logic                 push_ok;
    logic                 pop;
    logic                 fifo_full;

    function automatic logic [IW-1:0] lowest_index(input logic [NUM_DIR-1:0] m);
        logic [IW-1:0] idx;
        idx = '0;
        for (int k = NUM_DIR - 1; k >= 0; k--) begin
            if (m[k]) begin
                idx = IW'(k);
            end
        end
        return idx;
    endfunction

    always_comb begin
        keep_mask = '0;
        for (int k = 0; k < NUM_DIR; k++) begin
            keep_mask[k] = is_kept(move_in[k*MOVE_W +: MOVE_W], engineColor);
        end
    end

    assign sel_idx   = lowest_index(mask_q);
    assign sel_word  = bundle_q[sel_idx];
    assign mask_rest = mask_q & ~(NUM_DIR'(1) << sel_idx);

    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign push_ok   = !fifo_full || pop;
    assign accept    = in_ready && in_valid;

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        push     = 1'b0;
        in_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid && (keep_mask != '0)) begin
                    mask_d  = keep_mask;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // Without FIFO room the mask and state simply hold.
                if (push_ok) begin
                    push   = 1'b1;
                    mask_d = mask_rest;
                    if (mask_rest == '0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q       <= ST_IDLE;
            mask_q        <= '0;
            moves_total_q <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            if (push) begin
                moves_total_q <= moves_total_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < NUM_DIR; k++) begin
                bundle_q[k] <= move_in[k*MOVE_W +: MOVE_W];
            end
        end
    end

    move_fifo #(
        .WIDTH (MOVE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .clear_n   (clear_n),
        .push      (push),
        .push_data (sel_word),
        .pop       (pop),
        .head      (move_out),
        .count     (fifo_count),
        .full      (fifo_full)
    );

    assign moves_total = moves_total_q;
    assign busy        = (state_q == ST_SCAN);

endmodule

// File: tb/tb_move_collector.sv
// Directed bench for move_collector with a 4-entry FIFO.
module tb_move_collector;

    localparam int MOVE_W  = 32;
    localparam int NUM_DIR = 16;
    localparam int DEPTH   = 4;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic                      clk = 1'b0;
    logic                      clear_n = 1'b0;
    logic                      engineColor = 1'b0;
    logic                      in_valid = 1'b0;
    logic                      out_ready = 1'b0;
    logic [NUM_DIR*MOVE_W-1:0] move_in = '0;
    logic                      in_ready;
    logic                      out_valid;
    logic [MOVE_W-1:0]         move_out;
    logic [CW-1:0]             fifo_count;
    logic [15:0]               moves_total;
    logic                      busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    move_collector #(
        .MOVE_W  (MOVE_W),
        .NUM_DIR (NUM_DIR),
        .DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .clear_n     (clear_n),
        .engineColor (engineColor),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .move_in     (move_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .move_out    (move_out),
        .fifo_count  (fifo_count),
        .moves_total (moves_total),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] blk_word(input int k);
        return 32'hA000_0100 | (32'(k) << 16) | 32'(k);
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},    64'(in_ready),    64'd1);
        check({tag, "_out_valid"},   64'(out_valid),   64'd0);
        check({tag, "_move_out"},    64'(move_out),    64'd0);
        check({tag, "_fifo_count"},  64'(fifo_count),  64'd0);
        check({tag, "_moves_total"}, 64'(moves_total), 64'd0);
        check({tag, "_busy"},        64'(busy),        64'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        #2;
        check_reset_values("rst");
        #10 clear_n = 1'b1;
        tick();

        // Two black moves, D then UUR
        engineColor = 1'b0;
        move_in[1*32 +: 32] = 32'h0014_181C;
        move_in[9*32 +: 32] = 32'h002B_011D;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        move_in  = '0;
        check("t1_e0_in_ready",  64'(in_ready),  64'd0);
        check("t1_e0_busy",      64'(busy),      64'd1);
        check("t1_e0_out_valid", 64'(out_valid), 64'd0);
        tick();
        check("t1_e1_out_valid", 64'(out_valid),  64'd1);
        check("t1_e1_move_out",  64'(move_out),   64'h0014_181C);
        check("t1_e1_count",     64'(fifo_count), 64'd1);
        check("t1_e1_in_ready",  64'(in_ready),   64'd0);
        tick();
        check("t1_e2_in_ready",  64'(in_ready),    64'd1);
        check("t1_e2_count",     64'(fifo_count),  64'd2);
        check("t1_e2_total",     64'(moves_total), 64'd2);
        check("t1_e2_move_out",  64'(move_out),    64'h0014_181C);
        out_ready = 1'b1;
        tick();
        check("t1_pop1_move_out", 64'(move_out),   64'h002B_011D);
        check("t1_pop1_count",    64'(fifo_count), 64'd1);
        tick();
        out_ready = 1'b0;
        check("t1_pop2_out_valid", 64'(out_valid), 64'd0);
        check("t1_pop2_move_out",  64'(move_out),  64'd0);

        // White move while black to move: dropped
        move_in[3*32 +: 32] = 32'h0014_381C;
        in_valid = 1'b1;
        tick();
        check("t2_in_ready",  64'(in_ready),    64'd1);
        check("t2_busy",      64'(busy),        64'd0);
        check("t2_out_valid", 64'(out_valid),   64'd0);
        tick();
        in_valid = 1'b0;
        move_in  = '0;
        check("t2_b2_in_ready",  64'(in_ready),    64'd1);
        check("t2_b2_out_valid", 64'(out_valid),   64'd0);
        check("t2_total",        64'(moves_total), 64'd2);

        // Sixteen black moves into a 4-deep FIFO with no consumer
        for (int k = 0; k < NUM_DIR; k++) begin
            move_in[k*32 +: 32] = blk_word(k);
        end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        move_in  = '0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("t3_fill_count", 64'(fifo_count), 64'(k));
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t3_stall_count",    64'(fifo_count),  64'd4);
            check("t3_stall_busy",     64'(busy),        64'd1);
            check("t3_stall_total",    64'(moves_total), 64'd6);
            check("t3_stall_move_out", 64'(move_out),    64'(blk_word(0)));
        end

        // Drain: push and pop share each edge while the scan continues
        out_ready = 1'b1;
        for (int j = 1; j < NUM_DIR; j++) begin
            tick();
            check("t4_move_out", 64'(move_out), 64'(blk_word(j)));
            check("t4_count", 64'(fifo_count), (j <= 12) ? 64'd4 : 64'(16 - j));
            check("t4_busy",  64'(busy),       (j < 12) ? 64'd1 : 64'd0);
        end
        tick();
        out_ready = 1'b0;
        check("t4_end_out_valid", 64'(out_valid),   64'd0);
        check("t4_end_total",     64'(moves_total), 64'd18);

        // Asynchronous clear after 3 of 8 pushes
        for (int k = 0; k < 8; k++) begin
            move_in[k*32 +: 32] = blk_word(k);
        end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        move_in  = '0;
        tick();
        tick();
        tick();
        check("t5_pre_count", 64'(fifo_count), 64'd3);
        #2 clear_n = 1'b0;
        #1;
        check_reset_values("t5_async");
        #2 clear_n = 1'b1;
        tick();
        tick();
        check("t5_after_count", 64'(fifo_count),  64'd0);
        check("t5_after_total", 64'(moves_total), 64'd0);
        check("t5_after_busy",  64'(busy),        64'd0);

        // White to move; color flipped mid-scan must not matter
        engineColor = 1'b1;
        move_in[0*32 +: 32] = 32'h0014_381C;
        move_in[3*32 +: 32] = blk_word(3);
        move_in[6*32 +: 32] = 32'h0016_3A1E;
        in_valid = 1'b1;
        tick();
        in_valid    = 1'b0;
        engineColor = 1'b0;
        move_in     = '0;
        check("t5_new_busy", 64'(busy), 64'd1);
        tick();
        check("t5_new_e1_move_out", 64'(move_out),   64'h0014_381C);
        check("t5_new_e1_count",    64'(fifo_count), 64'd1);
        tick();
        check("t5_new_e2_count",    64'(fifo_count),  64'd2);
        check("t5_new_e2_in_ready", 64'(in_ready),    64'd1);
        check("t5_new_e2_total",    64'(moves_total), 64'd2);

        // Head stable under back-pressure
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t6_hold_valid",    64'(out_valid), 64'd1);
            check("t6_hold_move_out", 64'(move_out),  64'h0014_381C);
        end
        out_ready = 1'b1;
        tick();
        check("t6_pop_move_out", 64'(move_out), 64'h0016_3A1E);
        tick();
        out_ready = 1'b0;
        check("t6_empty_valid", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
